// File: rtl/cordic_rot_arbiter.sv
// Round-robin front end that shares one pipelined CORDIC rotation core among
// N_REQ requesters, with per-requester credits and a latency-matched tag pipeline.
module cordic_rot_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DW      = 16,
  parameter int LAT     = 15,
  parameter int MAX_OUT = 4,
  localparam int IDW    = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int CW     = $clog2(MAX_OUT + 1)
) (
  input  logic                clk,
  input  logic                sclr_n,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ*DW-1:0] req_x,
  input  logic [N_REQ*DW-1:0] req_y,
  input  logic [N_REQ*DW-1:0] req_phase,
  output logic                core_sclr,
  output logic                core_nd,
  output logic [DW-1:0]       core_x,
  output logic [DW-1:0]       core_y,
  output logic [DW-1:0]       core_phase,
  input  logic                core_rdy,
  input  logic [DW-1:0]       core_xo,
  input  logic [DW-1:0]       core_yo,
  output logic                res_valid,
  output logic [IDW-1:0]      res_id,
  output logic [DW-1:0]       res_x,
  output logic [DW-1:0]       res_y,
  output logic                err
);

  logic [IDW-1:0]   ptr_r;
  logic [CW-1:0]    cnt_r     [N_REQ];
  logic [CW-1:0]    cnt_nxt_s [N_REQ];
  logic [N_REQ-1:0] elig_s;
  logic [N_REQ-1:0] grant_s;
  logic [N_REQ-1:0] dec_s;
  logic [IDW-1:0]   idx_s;
  logic             hit_s;
  logic [IDW-1:0]   gnt_id_s;
  logic             gnt_any_s;
  logic [IDW-1:0]   ptr_nxt_s;
  logic [DW-1:0]    sel_x_s, sel_y_s, sel_ph_s;
  logic             underflow_s;

  logic             core_nd_r;
  logic [IDW-1:0]   issue_id_r;
  logic [DW-1:0]    core_x_r, core_y_r, core_ph_r;
  logic [LAT:1]     tag_v_r;
  logic [IDW-1:0]   tag_id_r  [LAT:1];
  logic             res_valid_r;
  logic [IDW-1:0]   res_id_r;
  logic [DW-1:0]    res_x_r, res_y_r;
  logic             err_r;

  // Eligibility, rotating-priority search from ptr and operand mux of the winner.
  always_comb begin
    grant_s   = '0;
    gnt_id_s  = '0;
    gnt_any_s = 1'b0;
    idx_s     = '0;
    hit_s     = 1'b0;
    sel_x_s   = '0;
    sel_y_s   = '0;
    sel_ph_s  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      elig_s[i] = req_valid[i] && (cnt_r[i] < CW'(MAX_OUT));
    end
    for (int k = 0; k < N_REQ; k++) begin
      idx_s          = IDW'((int'(ptr_r) + k) % N_REQ);
      hit_s          = elig_s[idx_s] && !gnt_any_s;
      grant_s[idx_s] = grant_s[idx_s] | hit_s;
      gnt_id_s       = hit_s ? idx_s : gnt_id_s;
      gnt_any_s      = gnt_any_s | hit_s;
    end
    // Nothing may be granted while the block is held in reset.
    grant_s   = grant_s & {N_REQ{sclr_n}};
    gnt_any_s = gnt_any_s & sclr_n;
    for (int k = 0; k < N_REQ; k++) begin
      sel_x_s  = sel_x_s  | ({DW{grant_s[k]}} & req_x[k*DW +: DW]);
      sel_y_s  = sel_y_s  | ({DW{grant_s[k]}} & req_y[k*DW +: DW]);
      sel_ph_s = sel_ph_s | ({DW{grant_s[k]}} & req_phase[k*DW +: DW]);
    end
    ptr_nxt_s = (gnt_id_s == IDW'(N_REQ - 1)) ? '0 : gnt_id_s + IDW'(1);
  end

  // Credit update: +1 on grant, -1 on returned result, underflow detection.
  always_comb begin
    cnt_nxt_s   = cnt_r;
    dec_s       = '0;
    underflow_s = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      dec_s[i] = res_valid_r && (res_id_r == IDW'(i));
      case ({grant_s[i], dec_s[i]})
        2'b10:   cnt_nxt_s[i] = cnt_r[i] + CW'(1);
        2'b01:   cnt_nxt_s[i] = (cnt_r[i] == '0) ? cnt_r[i] : cnt_r[i] - CW'(1);
        default: cnt_nxt_s[i] = cnt_r[i];
      endcase
      underflow_s = underflow_s | (dec_s[i] && (cnt_r[i] == '0));
    end
  end

  // Issue stage: core strobe/operands, pointer advance and tag stage 0.
  always_ff @(posedge clk or negedge sclr_n) begin
    if (!sclr_n) begin
      ptr_r      <= '0;
      core_nd_r  <= 1'b0;
      issue_id_r <= '0;
      core_x_r   <= '0;
      core_y_r   <= '0;
      core_ph_r  <= '0;
    end else begin
      core_nd_r  <= gnt_any_s;
      issue_id_r <= gnt_any_s ? gnt_id_s : '0;
      if (gnt_any_s) begin
        ptr_r     <= ptr_nxt_s;
        core_x_r  <= sel_x_s;
        core_y_r  <= sel_y_s;
        core_ph_r <= sel_ph_s;
      end
    end
  end

  // Tag shift register; stage LAT lines up with core_rdy of the same job.
  always_ff @(posedge clk or negedge sclr_n) begin
    if (!sclr_n) begin
      tag_v_r <= '0;
      for (int k = 1; k <= LAT; k++) tag_id_r[k] <= '0;
    end else begin
      tag_v_r[1]  <= core_nd_r;
      tag_id_r[1] <= issue_id_r;
      for (int k = 2; k <= LAT; k++) begin
        tag_v_r[k]  <= tag_v_r[k-1];
        tag_id_r[k] <= tag_id_r[k-1];
      end
    end
  end

  // Result stage, credit counters and sticky error flag.
  always_ff @(posedge clk or negedge sclr_n) begin
    if (!sclr_n) begin
      res_valid_r <= 1'b0;
      res_id_r    <= '0;
      res_x_r     <= '0;
      res_y_r     <= '0;
      err_r       <= 1'b0;
      for (int i = 0; i < N_REQ; i++) cnt_r[i] <= '0;
    end else begin
      res_valid_r <= core_rdy && tag_v_r[LAT];
      res_id_r    <= tag_id_r[LAT];
      res_x_r     <= core_xo;
      res_y_r     <= core_yo;
      err_r       <= err_r | (core_rdy != tag_v_r[LAT]) | underflow_s;
      cnt_r       <= cnt_nxt_s;
    end
  end

  assign req_ready  = grant_s;
  assign core_sclr  = ~sclr_n;
  assign core_nd    = core_nd_r;
  assign core_x     = core_x_r;
  assign core_y     = core_y_r;
  assign core_phase = core_ph_r;
  assign res_valid  = res_valid_r;
  assign res_id     = res_id_r;
  assign res_x      = res_x_r;
  assign res_y      = res_y_r;
  assign err        = err_r;

endmodule

// File: tb/tb_cordic_rot_arbiter.sv
// Directed bench for cordic_rot_arbiter with a simple fixed-latency core model
// (xo = x + phase, yo = y - phase) so routed data can be hand-checked.
module tb_cordic_rot_arbiter;
  localparam int N_REQ = 4, DW = 16, LAT = 15, MAX_OUT = 4, IDW = 2;

  logic                clk = 1'b0;
  logic                sclr_n;
  logic [N_REQ-1:0]    req_valid, req_ready;
  logic [N_REQ*DW-1:0] req_x, req_y, req_phase;
  logic                core_sclr, core_nd, core_rdy;
  logic [DW-1:0]       core_x, core_y, core_phase, core_xo, core_yo;
  logic                res_valid, err;
  logic [IDW-1:0]      res_id;
  logic [DW-1:0]       res_x, res_y;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int g_id[$], g_cyc[$], r_id[$], r_x[$], r_y[$], r_cyc[$];
  int gb, rb;

  cordic_rot_arbiter #(.N_REQ(N_REQ), .DW(DW), .LAT(LAT), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .sclr_n(sclr_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_phase(req_phase), .core_sclr(core_sclr),
    .core_nd(core_nd), .core_x(core_x), .core_y(core_y), .core_phase(core_phase),
    .core_rdy(core_rdy), .core_xo(core_xo), .core_yo(core_yo), .res_valid(res_valid),
    .res_id(res_id), .res_x(res_x), .res_y(res_y), .err(err)
  );

  always #5 clk = ~clk;

  // Core model: LAT-cycle delay line, cleared by core_sclr; inj forces a stray strobe.
  logic [LAT-1:0] m_nd;
  logic [DW-1:0]  m_x [LAT];
  logic [DW-1:0]  m_y [LAT];
  logic           inj;
  always @(posedge clk or posedge core_sclr) begin
    if (core_sclr) begin
      m_nd <= '0;
      for (int k = 0; k < LAT; k++) begin m_x[k] <= '0; m_y[k] <= '0; end
    end else begin
      m_nd   <= {m_nd[LAT-2:0], core_nd};
      m_x[0] <= core_x + core_phase;
      m_y[0] <= core_y - core_phase;
      for (int k = 1; k < LAT; k++) begin m_x[k] <= m_x[k-1]; m_y[k] <= m_y[k-1]; end
    end
  end
  assign core_rdy = m_nd[LAT-1] | inj;
  assign core_xo  = m_x[LAT-1];
  assign core_yo  = m_y[LAT-1];

  always @(posedge clk) cyc <= cyc + 1;

  // Record grants and results at the falling edge.
  always @(negedge clk) begin
    if (res_valid) begin
      r_id.push_back(int'(res_id)); r_x.push_back(int'(res_x));
      r_y.push_back(int'(res_y));   r_cyc.push_back(cyc);
    end
    for (int i = 0; i < N_REQ; i++)
      if (req_valid[i] && req_ready[i]) begin g_id.push_back(i); g_cyc.push_back(cyc); end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  initial begin
    #100000;
    $fatal(1, "FAIL watchdog timeout");
  end

  initial begin
    sclr_n = 1'b0; inj = 1'b0; req_valid = 4'hF;
    for (int i = 0; i < N_REQ; i++) begin
      req_x[i*DW +: DW]     = 16'((i + 1) * 256);
      req_y[i*DW +: DW]     = 16'((i + 1) * 16);
      req_phase[i*DW +: DW] = 16'(i + 1);
    end
    req_x[2*DW +: DW] = 16'd4096; req_y[2*DW +: DW] = 16'd0; req_phase[2*DW +: DW] = 16'd6434;

    // Reset state
    repeat (3) @(posedge clk); #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_nd", 32'(core_nd), 32'h0);
    chk("rst_res_valid", 32'(res_valid), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_core_sclr", 32'(core_sclr), 32'h1);
    req_valid = '0; sclr_n = 1'b1; #1;
    chk("rel_core_sclr", 32'(core_sclr), 32'h0);

    // Single job from requester 2
    @(posedge clk); #1; req_valid = 4'b0100; #1;
    chk("t1_ready", 32'(req_ready), 32'h4);
    @(posedge clk); #1; req_valid = '0;
    chk("t1_nd", 32'(core_nd), 32'h1);
    chk("t1_core_x", 32'(core_x), 32'd4096);
    chk("t1_core_phase", 32'(core_phase), 32'd6434);
    chk("t1_cnt_up", 32'(dut.cnt_r[2]), 32'd1);
    @(posedge clk); #1;
    chk("t1_nd_low", 32'(core_nd), 32'h0);
    repeat (LAT - 1) @(posedge clk); #1;
    chk("t1_early", 32'(res_valid), 32'h0);
    @(posedge clk); #1;
    chk("t1_res_valid", 32'(res_valid), 32'h1);
    chk("t1_res_id", 32'(res_id), 32'd2);
    chk("t1_res_x", 32'(res_x), 32'd10530);
    chk("t1_res_y", 32'(res_y), 32'hE6DE);
    @(posedge clk); #1;
    chk("t1_cnt_down", 32'(dut.cnt_r[2]), 32'd0);
    chk("t1_res_end", 32'(res_valid), 32'h0);
    req_x[2*DW +: DW] = 16'd768; req_y[2*DW +: DW] = 16'd48; req_phase[2*DW +: DW] = 16'd3;

    // Fairness: pointer sits at 3 after the grant to 2
    rb = r_id.size();
    req_valid = 4'b1010; #1;
    chk("rr_first", 32'(req_ready), 32'h8);
    @(posedge clk); #1;
    chk("rr_second", 32'(req_ready), 32'h2);
    @(posedge clk); #1; req_valid = '0;
    repeat (LAT + 4) @(posedge clk); #1;
    chk("rr_nres", 32'(r_id.size() - rb), 32'd2);
    chk("rr_id0", 32'(r_id[rb]), 32'd3);
    chk("rr_x0", 32'(r_x[rb]), 32'd1028);
    chk("rr_y0", 32'(r_y[rb]), 32'd60);
    chk("rr_id1", 32'(r_id[rb+1]), 32'd1);
    chk("rr_x1", 32'(r_x[rb+1]), 32'd514);
    chk("rr_b2b", 32'(r_cyc[rb+1] - r_cyc[rb]), 32'd1);

    // All four continuously valid right after reset
    sclr_n = 1'b0; @(posedge clk); #1; sclr_n = 1'b1;
    gb = g_id.size(); rb = r_id.size();
    req_valid = 4'hF;
    repeat (12) @(posedge clk); #1; req_valid = '0;
    repeat (LAT + 6) @(posedge clk); #1;
    chk("a4_ngrant", 32'(g_id.size() - gb), 32'd12);
    chk("a4_nres", 32'(r_id.size() - rb), 32'd12);
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("a4_gid%0d", k), 32'(g_id[gb+k]), 32'(k % 4));
      chk($sformatf("a4_rid%0d", k), 32'(r_id[rb+k]), 32'(k % 4));
      chk($sformatf("a4_rx%0d", k), 32'(r_x[rb+k]), 32'(257 * (k % 4 + 1)));
      chk($sformatf("a4_lat%0d", k), 32'(r_cyc[rb+k] - g_cyc[gb+k]), 32'(LAT + 2));
    end
    chk("a4_err", 32'(err), 32'h0);

    // Credit limit on requester 0
    req_valid = 4'b0001; #1;
    chk("cl_ready0", 32'(req_ready), 32'h1);
    for (int k = 1; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("cl_ready%0d", k), 32'(req_ready), 32'h1);
    end
    @(posedge clk); #1;
    chk("cl_blocked", 32'(req_ready), 32'h0);
    chk("cl_cnt_full", 32'(dut.cnt_r[0]), 32'd4);
    repeat (13) @(posedge clk); #1;
    chk("cl_first_res", 32'(res_valid), 32'h1);
    chk("cl_first_id", 32'(res_id), 32'd0);
    chk("cl_still_blocked", 32'(req_ready), 32'h0);
    @(posedge clk); #1;
    chk("cl_reassert", 32'(req_ready), 32'h1);
    chk("cl_cnt_3", 32'(dut.cnt_r[0]), 32'd3);
    @(posedge clk); #1;
    chk("cl_cnt_same", 32'(dut.cnt_r[0]), 32'd3);
    req_valid = '0;
    repeat (LAT + 6) @(posedge clk); #1;
    chk("cl_cnt_drain", 32'(dut.cnt_r[0]), 32'd0);

    // Asynchronous reset with five jobs in flight
    req_valid = 4'hF;
    repeat (5) @(posedge clk); #1;
    chk("mr_nd_before", 32'(core_nd), 32'h1);
    sclr_n = 1'b0; #1;
    chk("mr_nd", 32'(core_nd), 32'h0);
    chk("mr_core_x", 32'(core_x), 32'h0);
    chk("mr_core_phase", 32'(core_phase), 32'h0);
    chk("mr_ready", 32'(req_ready), 32'h0);
    chk("mr_res_valid", 32'(res_valid), 32'h0);
    chk("mr_core_sclr", 32'(core_sclr), 32'h1);
    req_valid = '0;
    repeat (2) @(posedge clk); #1; sclr_n = 1'b1;
    rb = r_id.size();
    for (int i = 0; i < N_REQ; i++)
      chk($sformatf("mr_cnt%0d", i), 32'(dut.cnt_r[i]), 32'd0);
    req_valid = 4'hF; #1;
    chk("mr_next_grant", 32'(req_ready), 32'h1);
    @(posedge clk); #1; req_valid = '0;
    repeat (LAT + 6) @(posedge clk); #1;
    chk("mr_nres", 32'(r_id.size() - rb), 32'd1);
    chk("mr_res_id", 32'(r_id[rb]), 32'd0);
    chk("mr_err", 32'(err), 32'h0);

    // Stray core_rdy with nothing in flight
    rb = r_id.size();
    @(posedge clk); #1; inj = 1'b1;
    @(posedge clk); #1; inj = 1'b0;
    chk("fi_err", 32'(err), 32'h1);
    chk("fi_res_valid", 32'(res_valid), 32'h0);
    repeat (5) @(posedge clk); #1;
    chk("fi_err_sticky", 32'(err), 32'h1);
    chk("fi_nres", 32'(r_id.size() - rb), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
